// File: rtl/ud_counter_host_seq.sv
// ---------------------------------------------------------------------------
// ud_counter_host_seq
//
// Bus-master sequencer that sits in front of the up/down counter block.
// A host hands over one configuration request (PLR, ULR, LLR, CCR). The
// sequencer range-checks it and writes the four registers over the counter's
// 8-bit strobed bus. It can optionally read them back and compare. It then
// pulses start and waits for end-of-count, an error flag or a timeout.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   cfg_valid/ready   request handshake (ready only while idle)
//   cfg_plr/ulr/llr/ccr  request values, captured on the handshake
//   verify_en         captured with the request; enables the readback pass
//   ncs, nwr, nrd     active-low chip select / write / read strobes
//   a1, a0            register address
//   dout, dout_oe     write data and its drive enable (tri-state is upstream)
//   din               read data from the counter
//   start             one-clock counter start pulse
//   ec, err_in        counter end-of-count and error flag
//   busy              high whenever not idle
//   done, fail        one-clock completion / abort pulses
//   fail_code         00 ok, 01 range/err, 10 readback mismatch, 11 timeout
// ---------------------------------------------------------------------------
module ud_counter_host_seq #(
    parameter int              STB_CYC = 2,
    parameter int              TO_W    = 16,
    parameter logic [TO_W-1:0] TIMEOUT = 16'hFFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [7:0] cfg_plr,
    input  logic [7:0] cfg_ulr,
    input  logic [7:0] cfg_llr,
    input  logic [7:0] cfg_ccr,
    input  logic       verify_en,
    output logic       ncs,
    output logic       nwr,
    output logic       nrd,
    output logic       a1,
    output logic       a0,
    output logic [7:0] dout,
    output logic       dout_oe,
    input  logic [7:0] din,
    output logic       start,
    input  logic       ec,
    input  logic       err_in,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [1:0] fail_code
);

    localparam int              SW       = (STB_CYC > 1) ? $clog2(STB_CYC) : 1;
    localparam logic [SW-1:0]   STB_LAST = SW'(STB_CYC - 1);
    localparam logic [TO_W:0]   TO_LIMIT = {1'b0, TIMEOUT};

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_W_SETUP, S_W_STB, S_W_HOLD,
        S_R_SETUP, S_R_STB, S_R_HOLD, S_START, S_RUN, S_DONE, S_FAIL
    } state_t;

    state_t          state_reg, state_next;
    logic [1:0]      idx_reg, idx_next;
    logic [SW-1:0]   stb_reg, stb_next;
    logic [TO_W-1:0] to_reg, to_next;
    logic            mismatch_reg, mismatch_next;
    logic [1:0]      fail_code_reg, fail_code_next;
    logic [7:0]      plr_reg, ulr_reg, llr_reg, ccr_reg;
    logic            verify_reg;

    logic            accept;
    logic [7:0]      cur_val;
    logic [TO_W:0]   to_inc;

    assign accept = (state_reg == S_IDLE) && cfg_valid;
    assign to_inc = {1'b0, to_reg} + 1'b1;

    // Register value for the current access index. Write and read passes use
    // the same value order; only the read address differs.
    always_comb begin
        cur_val = plr_reg;
        case (idx_reg)
            2'd0: cur_val = plr_reg;
            2'd1: cur_val = ulr_reg;
            2'd2: cur_val = llr_reg;
            2'd3: cur_val = ccr_reg;
            default: cur_val = plr_reg;
        endcase
    end

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            idx_reg       <= '0;
            stb_reg       <= '0;
            to_reg        <= '0;
            mismatch_reg  <= 1'b0;
            fail_code_reg <= 2'b00;
            plr_reg       <= '0;
            ulr_reg       <= '0;
            llr_reg       <= '0;
            ccr_reg       <= '0;
            verify_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            stb_reg       <= stb_next;
            to_reg        <= to_next;
            mismatch_reg  <= mismatch_next;
            fail_code_reg <= fail_code_next;
            if (accept) begin
                plr_reg    <= cfg_plr;
                ulr_reg    <= cfg_ulr;
                llr_reg    <= cfg_llr;
                ccr_reg    <= cfg_ccr;
                verify_reg <= verify_en;
            end
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        stb_next       = stb_reg;
        to_next        = to_reg;
        mismatch_next  = mismatch_reg;
        fail_code_next = fail_code_reg;

        case (state_reg)
            S_IDLE: begin
                if (cfg_valid) begin
                    state_next     = S_CHECK;
                    fail_code_next = 2'b00;
                end
            end
            S_CHECK: begin
                if ((plr_reg < llr_reg) || (plr_reg > ulr_reg) || (ccr_reg == 8'd0)) begin
                    state_next     = S_FAIL;
                    fail_code_next = 2'b01;
                end else begin
                    state_next = S_W_SETUP;
                    idx_next   = 2'd0;
                end
            end
            S_W_SETUP: begin
                state_next = S_W_STB;
                stb_next   = '0;
            end
            S_W_STB: begin
                if (stb_reg == STB_LAST) begin
                    state_next = S_W_HOLD;
                end else begin
                    stb_next = stb_reg + 1'b1;
                end
            end
            S_W_HOLD: begin
                if (idx_reg != 2'd3) begin
                    idx_next   = idx_reg + 2'd1;
                    state_next = S_W_SETUP;
                end else if (verify_reg) begin
                    idx_next   = 2'd0;
                    state_next = S_R_SETUP;
                end else begin
                    state_next = S_START;
                end
            end
            S_R_SETUP: begin
                state_next = S_R_STB;
                stb_next   = '0;
            end
            S_R_STB: begin
                // Read data is only trusted on the final strobe clock.
                if (stb_reg == STB_LAST) begin
                    mismatch_next = (din != cur_val);
                    state_next    = S_R_HOLD;
                end else begin
                    stb_next = stb_reg + 1'b1;
                end
            end
            S_R_HOLD: begin
                if (mismatch_reg) begin
                    state_next     = S_FAIL;
                    fail_code_next = 2'b10;
                end else if (idx_reg == 2'd3) begin
                    state_next = S_START;
                end else begin
                    idx_next   = idx_reg + 2'd1;
                    state_next = S_R_SETUP;
                end
            end
            S_START: begin
                state_next = S_RUN;
                to_next    = '0;
            end
            S_RUN: begin
                // Error has priority over a simultaneous end-of-count.
                if (err_in) begin
                    state_next     = S_FAIL;
                    fail_code_next = 2'b01;
                end else if (ec) begin
                    state_next     = S_DONE;
                    fail_code_next = 2'b00;
                end else if (to_inc >= TO_LIMIT) begin
                    state_next     = S_FAIL;
                    fail_code_next = 2'b11;
                end else if (to_reg != {TO_W{1'b1}}) begin
                    to_next = to_reg + 1'b1;
                end
            end
            S_DONE:  state_next = S_IDLE;
            S_FAIL:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        ncs     = 1'b1;
        nwr     = 1'b1;
        nrd     = 1'b1;
        a1      = 1'b0;
        a0      = 1'b0;
        dout    = 8'h00;
        dout_oe = 1'b0;
        start   = 1'b0;
        done    = 1'b0;
        fail    = 1'b0;

        case (state_reg)
            S_W_SETUP, S_W_STB, S_W_HOLD: begin
                ncs      = 1'b0;
                {a1, a0} = idx_reg;
                dout     = cur_val;
                dout_oe  = 1'b1;
                nwr      = (state_reg != S_W_STB);
            end
            S_R_SETUP, S_R_STB, S_R_HOLD: begin
                // Counter's read map swaps the two address bits.
                ncs      = 1'b0;
                {a1, a0} = {idx_reg[0], idx_reg[1]};
                nrd      = (state_reg != S_R_STB);
            end
            S_START: start = 1'b1;
            S_DONE:  done  = 1'b1;
            S_FAIL:  fail  = 1'b1;
            default: ;
        endcase
    end

    assign cfg_ready = (state_reg == S_IDLE);
    assign busy      = (state_reg != S_IDLE);
    assign fail_code = fail_code_reg;

endmodule

// File: tb/tb_ud_counter_host_seq.sv
// ---------------------------------------------------------------------------
// Self-checking bench for ud_counter_host_seq. A transaction-level model
// predicts bus accesses, start timing and the final outcome of each request.
// A small counter-side model answers reads from the written register contents.
// ---------------------------------------------------------------------------
module tb_ud_counter_host_seq;

    localparam int S = 2;        // strobe clocks
    localparam int T = 25;       // RUN timeout in clocks
    localparam int P = S + 2;    // clocks per access

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_plr = 8'h00, cfg_ulr = 8'h00, cfg_llr = 8'h00, cfg_ccr = 8'h00;
    logic       verify_en = 1'b0;
    logic       ncs, nwr, nrd, a1, a0;
    logic [7:0] dout;
    logic       dout_oe;
    logic [7:0] din = 8'h00;
    logic       start;
    logic       ec = 1'b0;
    logic       err_in = 1'b0;
    logic       busy, done, fail;
    logic [1:0] fail_code;

    int checks = 0;
    int failures = 0;
    int seq_n = 0;

    ud_counter_host_seq #(.STB_CYC(S), .TO_W(16), .TIMEOUT(16'(T))) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_plr(cfg_plr), .cfg_ulr(cfg_ulr), .cfg_llr(cfg_llr), .cfg_ccr(cfg_ccr),
        .verify_en(verify_en),
        .ncs(ncs), .nwr(nwr), .nrd(nrd), .a1(a1), .a0(a0),
        .dout(dout), .dout_oe(dout_oe), .din(din),
        .start(start), .ec(ec), .err_in(err_in),
        .busy(busy), .done(done), .fail(fail), .fail_code(fail_code)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (seq %0d)", tag, got, exp, seq_n);
        end
    endtask

    // One request from handshake to the clock after its done/fail pulse.
    // bad_rd: readback index answered with a corrupted value (4 = none).
    // ec_at/err_at: RUN clock (1-based) on which the flag is raised (0 = never).
    // hold: keep cfg_valid high throughout and expect re-acceptance in IDLE.
    task automatic run_seq(input logic [7:0] p, input logic [7:0] u,
                           input logic [7:0] l, input logic [7:0] c,
                           input bit ver, input int bad_rd,
                           input int ec_at, input int err_at, input bit hold);
        logic [7:0] vals [4];
        logic [1:0] rd_order [4];
        bit         range_bad, exp_done, exp_start, ended, got_done, got_fail;
        logic [1:0] exp_code, got_code, acc_a;
        logic [7:0] acc_d, resp;
        int         exp_wr, exp_rd, exp_end, exp_sc;
        int         cyc, wr_n, rd_n, wr_stb, rd_stb, ncs_low, start_n, sc_got, end_c;

        vals     = '{p, u, l, c};
        rd_order = '{2'b00, 2'b10, 2'b01, 2'b11};

        // ---- expectation from the request rules
        range_bad = (p < l) || (p > u) || (c == 8'd0);
        exp_sc = -1;
        exp_done = 1'b0;
        exp_start = 1'b0;
        if (range_bad) begin
            exp_wr = 0; exp_rd = 0; exp_code = 2'b01; exp_end = 1;
        end else begin
            exp_wr = 4;
            if (ver && bad_rd < 4) begin
                exp_rd = bad_rd + 1; exp_code = 2'b10;
                exp_end = 1 + 4 * P + exp_rd * P;
            end else begin
                exp_rd = ver ? 4 : 0;
                exp_start = 1'b1;
                exp_sc = 1 + P * (exp_wr + exp_rd);
                if (err_at > 0 && (ec_at == 0 || err_at <= ec_at)) begin
                    exp_code = 2'b01; exp_end = exp_sc + err_at + 1;
                end else if (ec_at > 0) begin
                    exp_done = 1'b1; exp_code = 2'b00; exp_end = exp_sc + ec_at + 1;
                end else begin
                    exp_code = 2'b11; exp_end = exp_sc + T + 1;
                end
            end
        end

        // ---- handshake
        @(negedge clk);
        cfg_plr = p; cfg_ulr = u; cfg_llr = l; cfg_ccr = c;
        verify_en = ver; cfg_valid = 1'b1;
        chk("ready_before", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        if (!hold) begin
            // Scramble inputs so only the captured copy can be used.
            cfg_valid = 1'b0;
            cfg_plr = 8'($urandom); cfg_ulr = 8'($urandom);
            cfg_llr = 8'($urandom); cfg_ccr = 8'($urandom);
            verify_en = ~ver;
        end

        cyc = 0; wr_n = 0; rd_n = 0; wr_stb = 0; rd_stb = 0; ncs_low = 0;
        start_n = 0; sc_got = -1; end_c = -1; ended = 1'b0;
        got_done = 1'b0; got_fail = 1'b0; got_code = 2'b00;
        acc_a = 2'b00; acc_d = 8'h00;

        while (!ended && cyc < 1000) begin
            if (!ncs) ncs_low++;
            if (!nwr) begin
                wr_stb++;
                chk("wr_frame", 32'({ncs, nrd, dout_oe}), 32'b011);
                if (wr_stb == 1) begin
                    acc_a = {a1, a0}; acc_d = dout;
                    chk("wr_addr", 32'(acc_a), 32'(wr_n & 3));
                    chk("wr_data", 32'(dout), 32'(vals[wr_n & 3]));
                end
            end else if (wr_stb > 0) begin
                chk("wr_len", 32'(wr_stb), 32'(S));
                chk("wr_hold", 32'({ncs, a1, a0, dout, dout_oe}), 32'({1'b0, acc_a, acc_d, 1'b1}));
                wr_n++; wr_stb = 0;
            end
            if (!nrd) begin
                rd_stb++;
                chk("rd_frame", 32'({ncs, nwr, dout_oe}), 32'b010);
                if (rd_stb == 1) begin
                    acc_a = {a1, a0};
                    chk("rd_addr", 32'(acc_a), 32'(rd_order[rd_n & 3]));
                end
                // Counter-side register file as seen through its read map.
                case (acc_a)
                    2'b00:   resp = p;
                    2'b10:   resp = u;
                    2'b01:   resp = l;
                    default: resp = c;
                endcase
                if (rd_n == bad_rd) resp = resp ^ 8'h01;
                din = (rd_stb == S) ? resp : (resp ^ 8'hA5);
            end else if (rd_stb > 0) begin
                chk("rd_len", 32'(rd_stb), 32'(S));
                chk("rd_hold", 32'({ncs, a1, a0, dout_oe}), 32'({1'b0, acc_a, 1'b0}));
                rd_n++; rd_stb = 0; din = 8'h00;
            end
            if (start) begin
                start_n++; sc_got = cyc;
                chk("start_ncs", 32'(ncs), 32'd1);
            end
            if (done || fail) begin
                ended = 1'b1; got_done = done; got_fail = fail;
                got_code = fail_code; end_c = cyc;
            end
            ec     = (sc_got >= 0) && (ec_at > 0)  && (cyc == sc_got + ec_at);
            err_in = (sc_got >= 0) && (err_at > 0) && (cyc == sc_got + err_at);
            if (!ended) begin
                @(negedge clk);
                cyc++;
            end
        end
        ec = 1'b0; err_in = 1'b0; din = 8'h00;

        chk("seq_ended", 32'(ended), 32'd1);
        chk("outcome", 32'({got_done, got_fail}), 32'({exp_done, ~exp_done}));
        chk("code_at_pulse", 32'(got_code), 32'(exp_code));
        chk("end_cycle", 32'(end_c), 32'(exp_end));
        chk("write_count", 32'(wr_n), 32'(exp_wr));
        chk("read_count", 32'(rd_n), 32'(exp_rd));
        chk("start_count", 32'(start_n), 32'(exp_start));
        if (exp_start) chk("start_cycle", 32'(sc_got), 32'(exp_sc));
        chk("ncs_low_clks", 32'(ncs_low), 32'((exp_wr + exp_rd) * P));

        @(negedge clk);
        chk("pulse_width", 32'({done, fail}), 32'd0);
        chk("idle_ready", 32'({cfg_ready, busy}), 32'b10);
        chk("code_held", 32'(fail_code), 32'(exp_code));
        if (hold) begin
            @(negedge clk);
            chk("reaccept", 32'(busy), 32'd1);
        end
        $display("seq %0d plr=%02h ulr=%02h llr=%02h ccr=%02h ver=%0d bad_rd=%0d ec_at=%0d err_at=%0d -> %s code=%0d at clk %0d",
                 seq_n, p, u, l, c, ver, bad_rd, ec_at, err_at,
                 got_done ? "done" : "abort", got_code, end_c);
        seq_n++;
    endtask

    initial begin
        logic [7:0] p, u, l, c;
        int r, bad_rd, ec_at, err_at, k;
        bit ver;

        // ---- reset state
        repeat (3) @(negedge clk);
        chk("rst_strobes", 32'({ncs, nwr, nrd}), 32'b111);
        chk("rst_addr_data", 32'({a1, a0, dout, dout_oe}), 32'd0);
        chk("rst_flags", 32'({start, busy, done, fail}), 32'd0);
        chk("rst_code", 32'(fail_code), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        rst = 1'b0;

        // ---- directed cases
        run_seq(8'h05, 8'h0A, 8'h02, 8'h03, 1'b0, 4, 20, 0, 1'b0);
        run_seq(8'h05, 8'h0A, 8'h02, 8'h03, 1'b1, 4, 5, 0, 1'b0);
        run_seq(8'h05, 8'h0A, 8'h02, 8'h03, 1'b1, 1, 5, 0, 1'b0);
        run_seq(8'h01, 8'h0A, 8'h02, 8'h01, 1'b0, 4, 5, 0, 1'b0);
        run_seq(8'h05, 8'h0A, 8'h02, 8'h00, 1'b0, 4, 5, 0, 1'b0);
        run_seq(8'h05, 8'h0A, 8'h02, 8'h03, 1'b0, 4, 7, 7, 1'b0);
        run_seq(8'h05, 8'h0A, 8'h02, 8'h03, 1'b0, 4, 0, 0, 1'b0);
        run_seq(8'h07, 8'h07, 8'h07, 8'h01, 1'b1, 4, T - 1, 0, 1'b0);
        run_seq(8'h00, 8'hFF, 8'h00, 8'hFF, 1'b1, 3, 1, 0, 1'b0);

        // ---- randomized requests
        for (int n = 0; n < 40; n++) begin
            l = 8'($urandom_range(0, 200));
            u = 8'($urandom_range(32'(l), 255));
            p = 8'($urandom_range(32'(l), 32'(u)));
            c = 8'($urandom_range(1, 255));
            r = int'($urandom_range(0, 9));
            if (r == 0) c = 8'h00;
            else if (r == 1) begin if (l > 8'd0) p = l - 8'd1; else c = 8'h00; end
            else if (r == 2) begin if (u < 8'hFF) p = u + 8'd1; else c = 8'h00; end
            ver = 1'($urandom);
            bad_rd = (ver && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 4;
            ec_at  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, T - 1));
            err_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, T - 1)) : 0;
            run_seq(p, u, l, c, ver, bad_rd, ec_at, err_at, 1'b0);
        end

        // ---- held request is re-accepted only in IDLE, then reset mid-strobe
        run_seq(8'h05, 8'h0A, 8'h02, 8'h03, 1'b0, 4, 3, 0, 1'b1);
        k = 0;
        while (nwr !== 1'b0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("reach_wr_strobe", 32'(nwr), 32'd0);
        rst = 1'b1;
        cfg_valid = 1'b0;
        #1;
        chk("arst_strobes", 32'({ncs, nwr, nrd}), 32'b111);
        chk("arst_bus", 32'({dout_oe, dout}), 32'd0);
        chk("arst_busy_ready", 32'({busy, cfg_ready}), 32'b01);
        chk("arst_start_code", 32'({start, fail_code}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_idle", 32'({start, ncs, busy, done, fail}), 32'b01000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ud_counter_host_seq.md
Name: ud_counter_host_seq

Overview:
- Bus-master sequencer directly upstream of the up/down counter block.
- Accepts one configuration request of four values: PLR (preload), ULR (upper limit), LLR (lower limit) and CCR (cycle count).
- Programs the four values over the counter's 8-bit strobed bus (ncs/nwr/nrd/A1/A0/din), optionally reads them back, pulses start, then waits for end-of-count.
- Reports done or a fail code to the host; the data bus is split into out/oe/in, and the tri-state buffer lives at top level.

Parameters:
STB_CYC, 2, clocks nwr/nrd held low per access (>=1)
TO_W, 16, width of end-of-count timeout counter
TIMEOUT, 16'hFFFF, clocks in RUN without ec before timeout fail

Ports:
clk  in  1  clock
rst  in  1  reset
cfg_valid  in  1  host request valid
cfg_ready  out  1  high only in IDLE; transfer on cfg_valid&&cfg_ready
cfg_plr  in  8  preload value
cfg_ulr  in  8  upper limit
cfg_llr  in  8  lower limit
cfg_ccr  in  8  cycle count
verify_en  in  1  sampled with request; 1 = readback pass after writes
ncs  out  1  chip select, active low
nwr  out  1  write strobe, active low
nrd  out  1  read strobe, active low
a1  out  1  address bit 1
a0  out  1  address bit 0
dout  out  8  bus write data
dout_oe  out  1  drive enable for dout
din  in  8  bus read data
start  out  1  counter start
ec  in  1  counter end-of-count
err_in  in  1  counter error flag
busy  out  1  high in any state except IDLE
done  out  1  one-clock pulse, sequence completed OK
fail  out  1  one-clock pulse, sequence aborted
fail_code  out  2  00 none, 01 range/err, 10 readback mismatch, 11 timeout; held until next accepted request

Behaviour:
- Reset (rst, asynchronous, active-high; clock clk) sets the following and returns the FSM to IDLE from any state, mid-access included:
  - ncs=nwr=nrd=1, a1=a0=0, dout=0, dout_oe=0.
  - start=0, busy=0, done=0, fail=0, fail_code=00.
- Request capture:
  - Inputs latched into internal regs on the transfer.
  - cfg_valid outside IDLE is ignored.
- States: IDLE, CHECK, W_SETUP, W_STB, W_HOLD, R_SETUP, R_STB, R_HOLD, START, RUN, DONE, FAIL.
- CHECK (1 clk) fails with code 01 if any of the following holds; otherwise goes to W_SETUP with idx=0:
  - plr<llr
  - plr>ulr
  - ccr==0
- Write address map (idx -> A1A0/value): 0 -> 00/plr, 1 -> 01/ulr, 2 -> 10/llr, 3 -> 11/ccr.
- Write access:
  - W_SETUP (1 clk): ncs=0, address and dout valid, dout_oe=1, strobes high.
  - W_STB (STB_CYC clks): nwr=0, nrd=1.
  - W_HOLD (1 clk): nwr=1; ncs, address and dout unchanged.
  - ncs, dout and dout_oe go high/low in the next state only.
- After W_HOLD:
  - idx<3 -> idx+1, W_SETUP.
  - idx==3 -> R_SETUP with idx=0 if verify_en, else START.
- Read address map differs from the write map (idx -> A1A0/expected value): 0 -> 00/plr, 1 -> 10/ulr, 2 -> 01/llr, 3 -> 11/ccr.
- Read access:
  - Same setup/strobe/hold framing as a write, with nrd=0 during R_STB and dout_oe=0 throughout.
  - din is sampled on the last R_STB clock.
  - Mismatch -> FAIL code 10 after R_HOLD; the remaining reads are skipped.
  - All four reads match -> START.
- START (1 clk): start=1, ncs=1; then RUN with start=0 and the timeout counter cleared.
- RUN:
  - ec=1 -> DONE.
  - err_in=1 -> FAIL code 01. If ec and err_in are high in the same clock, err_in wins.
  - Counter reaching TIMEOUT -> FAIL code 11.
  - The timeout counter saturates and never wraps.
- DONE: done=1 for 1 clk, fail_code=00, then IDLE.
- FAIL: fail=1 for 1 clk, fail_code set, then IDLE.
- busy is low in the same cycle cfg_ready is high.

Test Plan:
- Reset mid-W_STB (nwr=0) -> next edge: nwr=1, ncs=1, dout_oe=0, busy=0, cfg_ready=1; no start.
- Request plr=05 ulr=0A llr=02 ccr=03, verify_en=0, STB_CYC=2 -> four accesses at A1A0 00,01,10,11 with dout 05,0A,02,03, each 4 clks (setup+2 strobe+hold) -> 1-clk start -> ec at RUN clk 20 -> done pulse, fail_code=00.
- Same request with verify_en=1, bench returns 05,0A,02,03 for reads at 00,10,01,11 -> start issued. Return 0B at read idx1 -> fail, fail_code=10, no start, reads idx2/3 absent.
- plr=01 llr=02 ulr=0A, ccr=01 -> fail after CHECK, code 01, ncs never low. Separately ccr=00 -> fail, code 01.
- RUN with err_in and ec both asserted same clk -> fail, code 01, no done.
- TIMEOUT=16'd10, ec never asserted -> fail, code 11, exactly 10 clks after RUN entry. A cfg_valid held through the whole sequence is accepted only after return to IDLE.
